// File: rtl/readout_integrator_avg.sv
// Multi-lane I/Q shot integrator with optional 2^N shot averaging and a saturated
// valid/ready result port. One registered lane-sum stage feeds a wide accumulator.
module readout_integrator_avg #(
  parameter int LANES        = 5,
  parameter int DW           = 32,
  parameter int OUTW         = 32,
  parameter int AVG_MAX_LOG2 = 4
) (
  input  logic                   clk100,
  input  logic                   reset,
  input  logic                   trigger,
  input  logic [13:0]            delay_time,
  input  logic [10:0]            sample_length,
  input  logic [3:0]             avg_log2,
  input  logic                   in_valid,
  input  logic [LANES*DW-1:0]    data_i_rot,
  input  logic [LANES*DW-1:0]    data_q_rot,
  input  logic                   iq_ready,
  input  logic                   clear_flags,
  output logic                   iq_valid,
  output logic signed [OUTW-1:0] i_val,
  output logic signed [OUTW-1:0] q_val,
  output logic                   busy,
  output logic                   sat_flag,
  output logic                   trig_miss
);

  localparam int LSW  = DW + $clog2(LANES);
  localparam int ACCW = LSW + 11 + AVG_MAX_LOG2;
  localparam int SCW  = AVG_MAX_LOG2 + 1;
  localparam logic [3:0] AVG_CLAMP = 4'(AVG_MAX_LOG2);
  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic signed [ACCW-1:0] OUT_MAX = {{(ACCW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] OUT_MIN = {{(ACCW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_INTEG, S_FLUSH, S_ARMED, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic                   trig_prev_q, trig_edge;
  logic [13:0]            dly_q, dly_d, dcnt_q, dcnt_d;
  logic [10:0]            len_q, len_d, scnt_q, scnt_d;
  logic [3:0]             avg_q, avg_d;
  logic [SCW-1:0]         shot_q, shot_d;
  logic signed [LSW-1:0]  lsum_i_q, lsum_i_d, lsum_q_q, lsum_q_d;
  logic                   lsum_v_q, lsum_v_d;
  logic signed [ACCW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                   iq_valid_q, iq_valid_d;
  logic signed [OUTW-1:0] i_val_q, i_val_d, q_val_q, q_val_d;
  logic                   sat_q, sat_d, miss_q, miss_d;
  logic                   ovf_ai, ovf_aq, ovf_oi, ovf_oq, miss_set;

  function automatic logic signed [ACCW-1:0] acc_add(input logic signed [ACCW-1:0] a,
                                                     input logic signed [LSW-1:0]  b,
                                                     output logic                  ovf);
    logic signed [ACCW:0] s;
    s   = (ACCW+1)'(a) + (ACCW+1)'(b);
    ovf = s[ACCW] != s[ACCW-1];
    if (!ovf) return s[ACCW-1:0];
    return s[ACCW] ? ACC_MIN : ACC_MAX;
  endfunction

  function automatic logic signed [OUTW-1:0] out_sat(input logic signed [ACCW-1:0] v,
                                                     output logic                  ovf);
    ovf = 1'b0;
    if (v > OUT_MAX) begin
      ovf = 1'b1;
      return OUT_MAX[OUTW-1:0];
    end
    if (v < OUT_MIN) begin
      ovf = 1'b1;
      return OUT_MIN[OUTW-1:0];
    end
    return v[OUTW-1:0];
  endfunction

  assign trig_edge = trigger & ~trig_prev_q;

  always_comb begin
    lsum_i_d = '0;
    lsum_q_d = '0;
    for (int l = 0; l < LANES; l++) begin
      lsum_i_d = lsum_i_d + LSW'($signed(data_i_rot[l*DW +: DW]));
      lsum_q_d = lsum_q_d + LSW'($signed(data_q_rot[l*DW +: DW]));
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    len_d      = len_q;
    avg_d      = avg_q;
    dcnt_d     = dcnt_q;
    scnt_d     = scnt_q;
    shot_d     = shot_q;
    lsum_v_d   = 1'b0;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    iq_valid_d = iq_valid_q;
    i_val_d    = i_val_q;
    q_val_d    = q_val_q;
    ovf_ai     = 1'b0;
    ovf_aq     = 1'b0;
    ovf_oi     = 1'b0;
    ovf_oq     = 1'b0;
    miss_set   = 1'b0;

    if (lsum_v_q) begin
      acc_i_d = acc_add(acc_i_q, lsum_i_q, ovf_ai);
      acc_q_d = acc_add(acc_q_q, lsum_q_q, ovf_aq);
    end

    case (state_q)
      S_IDLE: if (trig_edge) begin
        dly_d   = delay_time;
        len_d   = sample_length;
        avg_d   = (avg_log2 > AVG_CLAMP) ? AVG_CLAMP : avg_log2;
        acc_i_d = '0;
        acc_q_d = '0;
        shot_d  = '0;
        dcnt_d  = '0;
        state_d = S_DELAY;
      end
      S_DELAY: begin
        miss_set = trig_edge;
        if (dcnt_q == dly_q) begin
          scnt_d  = '0;
          state_d = S_INTEG;
        end else begin
          dcnt_d = dcnt_q + 14'd1;
        end
      end
      S_INTEG: begin
        miss_set = trig_edge;
        if (len_q == 11'd0) begin
          state_d = S_FLUSH;
        end else if (in_valid) begin
          lsum_v_d = 1'b1;
          scnt_d   = scnt_q + 11'd1;
          if (scnt_q == len_q - 11'd1) state_d = S_FLUSH;
        end
      end
      // The last captured lane sum lands in the accumulator during this cycle.
      S_FLUSH: begin
        miss_set = trig_edge;
        shot_d   = shot_q + SCW'(1);
        state_d  = (shot_d == (SCW'(1) << avg_q)) ? S_OUT : S_ARMED;
      end
      S_ARMED: if (trig_edge) begin
        dcnt_d  = '0;
        state_d = S_DELAY;
      end
      S_OUT: begin
        miss_set = trig_edge;
        if (!iq_valid_q) begin
          i_val_d    = out_sat(acc_i_q >>> avg_q, ovf_oi);
          q_val_d    = out_sat(acc_q_q >>> avg_q, ovf_oq);
          iq_valid_d = 1'b1;
        end else if (iq_ready) begin
          iq_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sat_d  = ovf_ai | ovf_aq | ovf_oi | ovf_oq | (sat_q & ~clear_flags);
    miss_d = miss_set | (miss_q & ~clear_flags);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      trig_prev_q <= 1'b0;
      dly_q       <= '0;
      len_q       <= '0;
      avg_q       <= '0;
      dcnt_q      <= '0;
      scnt_q      <= '0;
      shot_q      <= '0;
      lsum_i_q    <= '0;
      lsum_q_q    <= '0;
      lsum_v_q    <= 1'b0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      iq_valid_q  <= 1'b0;
      i_val_q     <= '0;
      q_val_q     <= '0;
      sat_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trigger;
      dly_q       <= dly_d;
      len_q       <= len_d;
      avg_q       <= avg_d;
      dcnt_q      <= dcnt_d;
      scnt_q      <= scnt_d;
      shot_q      <= shot_d;
      lsum_i_q    <= lsum_i_d;
      lsum_q_q    <= lsum_q_d;
      lsum_v_q    <= lsum_v_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      iq_valid_q  <= iq_valid_d;
      i_val_q     <= i_val_d;
      q_val_q     <= q_val_d;
      sat_q       <= sat_d;
      miss_q      <= miss_d;
    end
  end

  assign iq_valid  = iq_valid_q;
  assign i_val     = i_val_q;
  assign q_val     = q_val_q;
  assign busy      = (state_q != S_IDLE);
  assign sat_flag  = sat_q;
  assign trig_miss = miss_q;

endmodule

// File: tb/tb_readout_integrator_avg.sv
// Self-checking bench for readout_integrator_avg: directed scenarios plus random shots
// compared against an exact 64-bit arithmetic model of shot sums and averaging.
module tb_readout_integrator_avg;
  localparam int LANES = 5;
  localparam int DW    = 32;
  localparam int OUTW  = 32;
  localparam int W     = LANES * DW;
  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  logic clk100 = 1'b0, reset = 1'b1, trigger = 1'b0, in_valid = 1'b0;
  logic iq_ready = 1'b0, clear_flags = 1'b0;
  logic [13:0] delay_time = '0;
  logic [10:0] sample_length = '0;
  logic [3:0]  avg_log2 = '0;
  logic [W-1:0] data_i_rot = '0, data_q_rot = '0;
  logic iq_valid, busy, sat_flag, trig_miss;
  logic signed [OUTW-1:0] i_val, q_val;

  int total = 0, bad = 0;
  longint mdl_i, mdl_q;
  bit exp_sat = 1'b0;

  always #5 clk100 = ~clk100;

  readout_integrator_avg #(.LANES(LANES), .DW(DW), .OUTW(OUTW), .AVG_MAX_LOG2(4)) dut (
    .clk100(clk100), .reset(reset), .trigger(trigger), .delay_time(delay_time),
    .sample_length(sample_length), .avg_log2(avg_log2), .in_valid(in_valid),
    .data_i_rot(data_i_rot), .data_q_rot(data_q_rot), .iq_ready(iq_ready),
    .clear_flags(clear_flags), .iq_valid(iq_valid), .i_val(i_val), .q_val(q_val),
    .busy(busy), .sat_flag(sat_flag), .trig_miss(trig_miss)
  );

  task automatic check(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] splat(input longint v);
    logic [W-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_lanes();
    logic [W-1:0] r;
    for (int l = 0; l < LANES; l++) begin
      logic signed [DW-1:0] x;
      x = $urandom;
      r[l*DW +: DW] = x >>> $urandom_range(0, 30);
    end
    return r;
  endfunction

  function automatic longint lane_total(input logic [W-1:0] v);
    longint s;
    s = 0;
    for (int l = 0; l < LANES; l++) begin
      logic signed [DW-1:0] x;
      x = v[l*DW +: DW];
      s += longint'(x);
    end
    return s;
  endfunction

  function automatic longint sat_out(input longint v);
    if (v > MAXP) begin exp_sat = 1'b1; return MAXP; end
    if (v < MINN) begin exp_sat = 1'b1; return MINN; end
    return v;
  endfunction

  // One shot: trigger edge, then per-cycle stimulus; lat = edges after the trigger edge
  // until iq_valid is first seen (-1 if never). Invalid cycles carry garbage data.
  task automatic run_shot(input int dly, input int len, input int avg, input bit cfg,
                          input int mode, input logic [W-1:0] di, input logic [W-1:0] dq,
                          output int lat);
    int budget;
    bit v;
    @(posedge clk100); #1;
    trigger  = 1'b1;
    in_valid = 1'b0;
    if (cfg) begin
      delay_time = 14'(dly); sample_length = 11'(len); avg_log2 = 4'(avg);
    end else begin
      delay_time = 14'($urandom); sample_length = 11'($urandom); avg_log2 = 4'($urandom);
    end
    @(posedge clk100); #1;
    trigger = 1'b0;
    delay_time = 14'($urandom); sample_length = 11'($urandom); avg_log2 = 4'($urandom);
    lat    = -1;
    budget = dly + 2 * len + 40;
    for (int k = 1; k <= budget; k++) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = (k >= 24) || ($urandom_range(0, 1) == 1);
      endcase
      in_valid   = v;
      data_i_rot = v ? di : rand_lanes();
      data_q_rot = v ? dq : rand_lanes();
      @(posedge clk100); #1;
      if (lat < 0 && iq_valid) lat = k;
    end
    in_valid = 1'b0;
    mdl_i += longint'(len) * lane_total(di);
    mdl_q += longint'(len) * lane_total(dq);
  endtask

  task automatic check_result(input string tag, input int avg);
    int a;
    longint ei, eq;
    a  = (avg > 4) ? 4 : avg;
    ei = sat_out(mdl_i >>> a);
    eq = sat_out(mdl_q >>> a);
    check({tag, "_valid"}, iq_valid, 1);
    check({tag, "_i"}, i_val, ei);
    check({tag, "_q"}, q_val, eq);
    check({tag, "_sat"}, sat_flag, exp_sat);
  endtask

  task automatic consume(input string tag);
    iq_ready = 1'b1;
    @(posedge clk100); #1;
    iq_ready = 1'b0;
    check({tag, "_drop"}, iq_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(posedge clk100); #1;
    clear_flags = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, dly, len, avg, a;
    int avg_pick[4] = '{0, 1, 2, 9};

    repeat (3) @(posedge clk100);
    #1;
    check("rst_valid", iq_valid, 0);
    check("rst_i", i_val, 0);
    check("rst_q", q_val, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_miss", trig_miss, 0);
    reset = 1'b0;

    // Basic shot; first counted sample is delay+2 edges after the trigger edge,
    // result two edges after the last counted sample.
    mdl_i = 0; mdl_q = 0;
    run_shot(3, 4, 0, 1'b1, 0, splat(100), splat(-50), lat);
    check("t1_latency", lat, 3 + 4 + 3);
    check_result("t1", 0);
    check("t1_miss", trig_miss, 0);
    consume("t1");

    // Four-shot average.
    mdl_i = 0; mdl_q = 0;
    for (int s = 0; s < 4; s++) begin
      run_shot(2, 4, 2, s == 0, 0, splat(10 * (s + 1)), splat(0), lat);
      if (s < 3) begin
        check($sformatf("t2_early_valid%0d", s), lat, -1);
        check($sformatf("t2_armed_busy%0d", s), busy, 1);
      end
    end
    check_result("t2", 2);
    consume("t2");

    // Alternating in_valid: four counted samples span seven INTEG cycles.
    mdl_i = 0; mdl_q = 0;
    run_shot(2, 4, 0, 1'b1, 1, splat(1), splat(0), lat);
    check("t3_latency", lat, 2 + 7 + 3);
    check_result("t3", 0);

    // Result held with back-pressure while two triggers arrive.
    for (int c = 0; c < 20; c++) begin
      trigger = (c == 3 || c == 9);
      @(posedge clk100); #1;
    end
    trigger = 1'b0;
    check("t4_miss", trig_miss, 1);
    check("t4_i_stable", i_val, 20);
    check("t4_valid_held", iq_valid, 1);
    pulse_clear();
    check("t4_miss_clr", trig_miss, 0);
    consume("t4");

    // Full-length shot at extreme inputs saturates the output.
    mdl_i = 0; mdl_q = 0;
    run_shot(0, 2047, 0, 1'b1, 0, splat(MAXP), splat(MINN), lat);
    check_result("t5", 0);
    check("t5_i_hex", i_val, MAXP);
    pulse_clear();
    exp_sat = 1'b0;
    check("t5_sat_clr", sat_flag, 0);
    consume("t5");

    // Reset in the middle of integration, then a clean shot.
    @(posedge clk100); #1;
    trigger = 1'b1; delay_time = 14'd1; sample_length = 11'd50; avg_log2 = 4'd0;
    @(posedge clk100); #1;
    trigger = 1'b0; in_valid = 1'b1;
    data_i_rot = splat(777); data_q_rot = splat(333);
    repeat (8) @(posedge clk100);
    #1;
    check("t6_busy_pre", busy, 1);
    reset = 1'b1;
    #2;
    check("t6_busy", busy, 0);
    check("t6_valid", iq_valid, 0);
    check("t6_i", i_val, 0);
    check("t6_q", q_val, 0);
    check("t6_sat", sat_flag, 0);
    check("t6_miss", trig_miss, 0);
    @(posedge clk100); #1;
    reset = 1'b0; in_valid = 1'b0;
    mdl_i = 0; mdl_q = 0;
    run_shot(0, 4, 0, 1'b1, 0, splat(100), splat(-50), lat);
    check("t6_latency", lat, 0 + 4 + 3);
    check_result("t6", 0);
    consume("t6");

    // Random shots, gappy in_valid, changing config after latch, clamped averaging.
    for (int r = 0; r < 6; r++) begin
      dly = $urandom_range(0, 5);
      len = $urandom_range(0, 8);
      avg = avg_pick[$urandom_range(0, 3)];
      a   = (avg > 4) ? 4 : avg;
      mdl_i = 0; mdl_q = 0;
      for (int s = 0; s < (1 << a); s++)
        run_shot(dly, len, avg, s == 0, 2, rand_lanes(), rand_lanes(), lat);
      check_result($sformatf("rnd%0d", r), avg);
      consume($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
